// File: rtl/mic1_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mic1_mem_ctrl_if
// Description : Bundle of MIC-1 datapath request/result signals and
//               main_memory port signals around the memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface mic1_mem_ctrl_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 9,
    parameter int MBR_W  = 8
);
    // datapath -> controller
    logic              rd_req;
    logic              wr_req;
    logic              fetch_req;
    logic [ADDR_W-1:0] mar_in;
    logic [ADDR_W-1:0] pc_in;
    logic [DATA_W-1:0] mdr_in;
    // controller -> datapath
    logic              busy;
    logic [DATA_W-1:0] mdr_out;
    logic              mdr_valid;
    logic [MBR_W-1:0]  mbr_out;
    logic              mbr_valid;
    logic              protocol_err;
    // controller <-> main_memory
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ren;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata;

    // Controller side
    modport slave (
        input  rd_req, wr_req, fetch_req, mar_in, pc_in, mdr_in, mem_rdata,
        output busy, mdr_out, mdr_valid, mbr_out, mbr_valid, protocol_err,
        output mem_wen, mem_waddr, mem_wdata, mem_ren, mem_raddr
    );

    // Datapath + memory side
    modport master (
        output rd_req, wr_req, fetch_req, mar_in, pc_in, mdr_in, mem_rdata,
        input  busy, mdr_out, mdr_valid, mbr_out, mbr_valid, protocol_err,
        input  mem_wen, mem_waddr, mem_wdata, mem_ren, mem_raddr
    );
endinterface
`default_nettype wire

// File: rtl/mic1_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mic1_mem_ctrl
// Description : MIC-1 memory sequencer. Converts rd/wr/fetch commands into
//               main_memory strobes, arbitrates the single read port between
//               rd and fetch, and routes read data to MDR / MBR two edges
//               after issue. Illegal or rejected requests pulse protocol_err.
// Revision    : 1.0 - initial release
// ============================================================================
module mic1_mem_ctrl #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 9,
    parameter int MBR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    mic1_mem_ctrl_if.slave    bus
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DEFER = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;            // deferred fetch address

    // Read tag pipeline: issue stage (mem_ren cycle) and return stage
    // (mem_rdata valid cycle). fet=1 routes to MBR, fet=0 to MDR.
    logic              iss_vld_q, iss_vld_d;
    logic              iss_fet_q, iss_fet_d;
    logic              ret_vld_q, ret_fet_q;

    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ren_q, ren_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic              mdr_valid_q, mdr_valid_d;
    logic [MBR_W-1:0]  mbr_q, mbr_d;
    logic              mbr_valid_q, mbr_valid_d;

    logic              w_any_req;

    assign w_any_req = bus.rd_req | bus.wr_req | bus.fetch_req;

    // Next-state: command decode, read-port arbitration and result routing
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        iss_vld_d   = 1'b0;
        iss_fet_d   = 1'b0;
        wen_d       = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        ren_d       = 1'b0;
        raddr_d     = raddr_q;
        err_d       = 1'b0;
        mdr_d       = mdr_q;
        mbr_d       = mbr_q;
        mdr_valid_d = 1'b0;
        mbr_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                // Write port is independent of the read port
                if (bus.wr_req) begin
                    wen_d   = 1'b1;
                    waddr_d = bus.mar_in;
                    wdata_d = bus.mdr_in;
                end
                // rd+wr share MAR: the write wins, the read is dropped
                if (bus.rd_req && bus.wr_req) begin
                    err_d = 1'b1;
                end
                if (bus.rd_req && !bus.wr_req) begin
                    ren_d     = 1'b1;
                    raddr_d   = bus.mar_in;
                    iss_vld_d = 1'b1;
                    iss_fet_d = 1'b0;
                    // rd owns the port this cycle; park the fetch for one cycle
                    if (bus.fetch_req) begin
                        pc_d    = bus.pc_in;
                        state_d = DEFER;
                    end
                end else if (bus.fetch_req) begin
                    ren_d     = 1'b1;
                    raddr_d   = bus.pc_in;
                    iss_vld_d = 1'b1;
                    iss_fet_d = 1'b1;
                end
            end
            DEFER: begin
                // Issue the parked fetch; anything sampled now is rejected
                ren_d     = 1'b1;
                raddr_d   = pc_q;
                iss_vld_d = 1'b1;
                iss_fet_d = 1'b1;
                state_d   = IDLE;
                if (w_any_req) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Return stage: memory data is valid now, load the target register
        if (ret_vld_q) begin
            if (ret_fet_q) begin
                mbr_d       = bus.mem_rdata[MBR_W-1:0];
                mbr_valid_d = 1'b1;
            end else begin
                mdr_d       = bus.mem_rdata;
                mdr_valid_d = 1'b1;
            end
        end
    end

    // State and output registers; reset discards any in-flight read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            iss_vld_q   <= 1'b0;
            iss_fet_q   <= 1'b0;
            ret_vld_q   <= 1'b0;
            ret_fet_q   <= 1'b0;
            wen_q       <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            ren_q       <= 1'b0;
            raddr_q     <= '0;
            err_q       <= 1'b0;
            mdr_q       <= '0;
            mdr_valid_q <= 1'b0;
            mbr_q       <= '0;
            mbr_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            iss_vld_q   <= iss_vld_d;
            iss_fet_q   <= iss_fet_d;
            ret_vld_q   <= iss_vld_q;
            ret_fet_q   <= iss_fet_q;
            wen_q       <= wen_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            ren_q       <= ren_d;
            raddr_q     <= raddr_d;
            err_q       <= err_d;
            mdr_q       <= mdr_d;
            mdr_valid_q <= mdr_valid_d;
            mbr_q       <= mbr_d;
            mbr_valid_q <= mbr_valid_d;
        end
    end

    assign bus.busy         = (state_q == DEFER);
    assign bus.mdr_out      = mdr_q;
    assign bus.mdr_valid    = mdr_valid_q;
    assign bus.mbr_out      = mbr_q;
    assign bus.mbr_valid    = mbr_valid_q;
    assign bus.protocol_err = err_q;
    assign bus.mem_wen      = wen_q;
    assign bus.mem_waddr    = waddr_q;
    assign bus.mem_wdata    = wdata_q;
    assign bus.mem_ren      = ren_q;
    assign bus.mem_raddr    = raddr_q;

endmodule
`default_nettype wire

// File: tb/tb_mic1_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mic1_mem_ctrl
// Description : Self-checking bench for mic1_mem_ctrl with a main_memory
//               model and MDR/MBR scoreboards.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mic1_mem_ctrl;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 9;
    localparam int MBR_W  = 8;

    logic clk;
    logic rst;

    mic1_mem_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MBR_W(MBR_W)) bus ();

    mic1_mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MBR_W(MBR_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec;
    int n_err;
    int err_pulses;

    logic [DATA_W-1:0] mem       [2**ADDR_W];
    logic [DATA_W-1:0] model_mem [2**ADDR_W];
    logic [DATA_W-1:0] exp_mdr_q [$];
    logic [MBR_W-1:0]  exp_mbr_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // main_memory model: registered read, write at the edge
    always @(posedge clk) begin
        if (bus.mem_wen) mem[bus.mem_waddr] <= bus.mem_wdata;
        if (bus.mem_ren) bus.mem_rdata <= mem[bus.mem_raddr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {14'd0, bus.busy, bus.mdr_out, bus.mdr_valid, bus.mbr_out, bus.mbr_valid,
                bus.protocol_err, bus.mem_wen, bus.mem_waddr, bus.mem_wdata,
                bus.mem_ren, bus.mem_raddr};
    endfunction

    // Scoreboard: compare each returned result against the oldest expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.protocol_err) err_pulses++;
            if (bus.mdr_valid) begin
                if (exp_mdr_q.size() == 0) chk("sb_mdr_unexpected", 1, 0);
                else chk("sb_mdr", bus.mdr_out, exp_mdr_q.pop_front());
            end
            if (bus.mbr_valid) begin
                if (exp_mbr_q.size() == 0) chk("sb_mbr_unexpected", 1, 0);
                else chk("sb_mbr", bus.mbr_out, exp_mbr_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.rd_req = 0; bus.wr_req = 0; bus.fetch_req = 0;
    endtask

    task automatic preload(input int addr, input int data);
        bus.wr_req = 1; bus.mar_in = addr[ADDR_W-1:0]; bus.mdr_in = data[DATA_W-1:0];
        model_mem[addr] = data[DATA_W-1:0];
        tick();
        idle_in();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_vec = 0; n_err = 0; err_pulses = 0;
        rst = 1;
        idle_in();
        bus.mar_in = 0; bus.pc_in = 0; bus.mdr_in = 0;
        tick(); tick();
        chk("reset_outs", all_outs(), 0);
        rst = 0;
        tick();

        // 1: write then read
        bus.wr_req = 1; bus.mar_in = 10; bus.mdr_in = 99; model_mem[10] = 99;
        tick();                                              // E0
        chk("t1_wen", bus.mem_wen, 1);
        chk("t1_waddr", bus.mem_waddr, 10);
        chk("t1_wdata", bus.mem_wdata, 99);
        bus.wr_req = 0; bus.rd_req = 1; exp_mdr_q.push_back(model_mem[10]);
        tick();                                              // E1
        chk("t1_single_wen", bus.mem_wen, 0);
        chk("t1_ren", bus.mem_ren, 1);
        chk("t1_raddr", bus.mem_raddr, 10);
        idle_in();
        tick();                                              // E2
        chk("t1_mdr_valid_early", bus.mdr_valid, 0);
        tick();                                              // E3
        chk("t1_mdr_valid", bus.mdr_valid, 1);
        chk("t1_mdr_out", bus.mdr_out, 99);
        chk("t1_no_err", err_pulses, 0);

        // 2: fetch
        preload(5, 'h1A5);
        bus.fetch_req = 1; bus.pc_in = 5; exp_mbr_q.push_back(model_mem[5][MBR_W-1:0]);
        tick();                                              // E0
        chk("t2_ren", bus.mem_ren, 1);
        chk("t2_raddr", bus.mem_raddr, 5);
        idle_in();
        tick();
        chk("t2_mbr_valid_early", bus.mbr_valid, 0);
        tick();                                              // E2
        chk("t2_mbr_valid", bus.mbr_valid, 1);
        chk("t2_mbr_out", bus.mbr_out, 'hA5);
        chk("t2_mdr_hold", bus.mdr_out, 99);
        chk("t2_mdr_valid", bus.mdr_valid, 0);

        // 3: rd + fetch collision, then request while busy
        bus.rd_req = 1; bus.mar_in = 10; bus.fetch_req = 1; bus.pc_in = 5;
        exp_mdr_q.push_back(model_mem[10]);
        exp_mbr_q.push_back(model_mem[5][MBR_W-1:0]);
        tick();                                              // E0
        chk("t3_busy", bus.busy, 1);
        chk("t3_raddr_rd", bus.mem_raddr, 10);
        chk("t3_ren0", bus.mem_ren, 1);
        bus.fetch_req = 0; bus.rd_req = 1; bus.mar_in = 10;  // sampled while busy
        tick();                                              // E1
        chk("t3_raddr_fet", bus.mem_raddr, 5);
        chk("t3_ren1", bus.mem_ren, 1);
        chk("t3_busy_clear", bus.busy, 0);
        chk("t3_err", bus.protocol_err, 1);
        idle_in();
        tick();                                              // E2
        chk("t3_no_third_ren", bus.mem_ren, 0);
        chk("t3_err_pulse", bus.protocol_err, 0);
        chk("t3_mdr_valid", bus.mdr_valid, 1);
        chk("t3_mdr_out", bus.mdr_out, 99);
        tick();                                              // E3
        chk("t3_mbr_valid", bus.mbr_valid, 1);
        chk("t3_mbr_out", bus.mbr_out, 'hA5);
        tick(); tick();

        // 4: illegal rd + wr
        bus.rd_req = 1; bus.wr_req = 1; bus.mar_in = 3; bus.mdr_in = 7; model_mem[3] = 7;
        tick();                                              // E0
        chk("t4_wen", bus.mem_wen, 1);
        chk("t4_waddr", bus.mem_waddr, 3);
        chk("t4_wdata", bus.mem_wdata, 7);
        chk("t4_no_ren", bus.mem_ren, 0);
        chk("t4_err", bus.protocol_err, 1);
        idle_in();
        tick(); tick();
        chk("t4_no_mdr_valid", bus.mdr_valid, 0);
        bus.rd_req = 1; bus.mar_in = 3; exp_mdr_q.push_back(model_mem[3]);
        tick(); idle_in(); tick(); tick();
        chk("t4_readback", bus.mdr_out, 7);

        // 5: back-to-back reads
        preload(0, 4); preload(1, 5); preload(2, 6);
        for (int i = 0; i < 3; i++) begin
            bus.rd_req = 1; bus.mar_in = i[ADDR_W-1:0];
            exp_mdr_q.push_back(model_mem[i]);
            tick();
        end
        idle_in();
        chk("t5_mdr0_valid", bus.mdr_valid, 1);
        chk("t5_mdr0", bus.mdr_out, 4);
        tick();
        chk("t5_mdr1_valid", bus.mdr_valid, 1);
        chk("t5_mdr1", bus.mdr_out, 5);
        tick();
        chk("t5_mdr2_valid", bus.mdr_valid, 1);
        chk("t5_mdr2", bus.mdr_out, 6);
        tick();
        chk("t5_mdr_end", bus.mdr_valid, 0);

        // 6: asynchronous reset mid-read
        bus.rd_req = 1; bus.mar_in = 10;
        tick();                                              // E0
        idle_in();
        tick();                                              // E1
        #2 rst = 1;
        #1 chk("t6_async_outs", all_outs(), 0);
        tick(); tick();
        rst = 0;
        tick(); tick(); tick();
        chk("t6_no_valid_after", bus.mdr_valid, 0);
        bus.rd_req = 1; bus.mar_in = 10; exp_mdr_q.push_back(model_mem[10]);
        tick(); idle_in(); tick(); tick();
        chk("t6_read_after_valid", bus.mdr_valid, 1);
        chk("t6_read_after", bus.mdr_out, 99);
        tick(); tick();

        chk("sb_mdr_drain", exp_mdr_q.size(), 0);
        chk("sb_mbr_drain", exp_mbr_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
